uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver. It sits on the line side opposite the transmitter and consumes the serial stream it produces.
- Recovers 8-bit frames (start, 8 data LSB-first, optional parity, 1 stop) from asynchronous `rx`.
- Checks parity and framing, and presents each byte on a valid/ready output towards the host logic.
- Baud rate and parity are selected by the same `conf` byte layout the transmitter uses.

Parameters:
- FREQ, 50000000, system clock frequency in Hz.
- CONFIG_WIDTH, 8, width of `conf`.
- UART_DATA_WIDTH, 8, data bits per frame; only 8 is supported.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the next clock edge).
- rx  in  1  asynchronous serial input; idle high.
- dout  out  8  received byte.
- dout_valid  out  1  `dout` and the flags are valid.
- dout_ready  in  1  consumer accepts the byte.
- parity_err  out  1  parity mismatch for the byte in `dout`; qualified by `dout_valid`.
- frame_err  out  1  stop bit sampled low for the byte in `dout`; qualified by `dout_valid`.
- overrun  out  1  sticky; at least one frame was dropped since the last handshake.
- conf  in  CONFIG_WIDTH  [7:5] baud select, [1] parity enable, [0] 1=odd / 0=even.

Behaviour:
- Reset values:
  - `dout`=0, `dout_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0.
  - state=IDLE, counters=0.
  - Synchronizer flops=1.
- Synchronizer:
  - `rx` passes through 2 flops to give `rx_s`.
  - All sampling uses `rx_s`.
- Baud limit L:
  - L = FREQ/baud − 1 (integer division), baud selected by `conf[7:5]`.
  - Mapping: 0=1200, 1=2400, 2=4800, 3=9600, 4=19200, 5=38400, 6=57600, 7=115200.
  - Half limit H = L>>1.
  - `baud_cnt` is 32 bits. It counts 0..L and wraps to 0; it holds at 0 in IDLE.
- Config latch: `conf` is copied into `rx_conf` every cycle in IDLE and frozen otherwise. A `conf` change mid-frame has no effect until the next frame.
- States:
  - IDLE: `rx_s`==0 → START, `baud_cnt`=0.
  - START: when `baud_cnt`==H, sample `rx_s`. If it is 0 → DATA, with `baud_cnt` and `bit_cnt` cleared. If it is 1 (glitch) → IDLE, with no output.
  - DATA:
    - Every `baud_cnt`==L, shift `rx_s` into bit `bit_cnt` of the shift register (LSB first), then increment `bit_cnt`.
    - After the 8th sample: go to PARITY if `rx_conf[1]`, else STOP.
  - PARITY: at `baud_cnt`==L, sample p. Error if p != (^data ^ `rx_conf[0]`), i.e. even → p must equal XOR of data; odd → its inverse. Then → STOP.
  - STOP:
    - At `baud_cnt`==L, sample the stop bit.
    - Deliver the frame (see Output). `frame_err`=~stop.
    - Next state is IDLE if the stop bit is 1, else BREAK.
  - BREAK: wait until `rx_s`==1, then → IDLE. This prevents a held-low line from being taken as a new start bit.
- Output:
  - On the cycle after the stop-bit sample, if `dout_valid`==0 or (`dout_valid` & `dout_ready`): load `dout` and the error flags, and set `dout_valid`=1.
  - Otherwise the new frame is discarded, `overrun` is set, and the old `dout` and flags are held unchanged.
- Handshake:
  - `dout_valid` stays high until a cycle with `dout_ready`=1, and then drops the next cycle unless a new frame loads in that same cycle.
  - A simultaneous new frame and handshake loads the new frame; this is not an overrun.
- Overrun clear: `overrun` clears on a handshake unless an overrun occurs in the same cycle, in which case it stays set.
- Latency: `dout_valid` rises 1 cycle after the stop-bit mid-sample. Total from the start-bit falling edge ≈ 2 sync + H + 9 or 10 × (L+1) cycles.
- Reset mid-frame: returns to IDLE immediately. Any partial frame is lost, and no `dout_valid` is produced.

Decomposition:
- `uart_pkg`:
  - Baud-limit function `baud_limit(FREQ, sel)`.
  - `conf` field constants (CONF_BAUD_MSB=7, CONF_BAUD_LSB=5, CONF_PAR_EN=1, CONF_PAR_ODD=0).
  - State encoding localparams (IDLE, START, DATA, PARITY, STOP, BREAK).
  - The function and constants are shared with the transmitter.
- One sub-module, `uart_sync2`: a 2-flop synchronizer with reset value 1.

Test Plan (FREQ=1152000, so conf[7:5]=7 gives L=9, H=4):
- conf=8'hE0, send 0xA5 (no parity), `dout_ready`=1 → `dout`=0xA5, `dout_valid` pulses 1 cycle, `parity_err`=0, `frame_err`=0.
- conf=8'hE2 (even) send 0x03 with p=0 → `parity_err`=0. Resend with p=1 → `parity_err`=1, `dout`=0x03. conf=8'hE3 (odd) with p=1 → `parity_err`=0.
- 3-cycle low glitch on `rx` (shorter than H) → returns to IDLE and `dout_valid` never asserts. A following real frame 0x5A is received correctly.
- Frame 0x7E with stop bit driven 0, then line held low for 20 bit times, then high → `frame_err`=1, `dout`=0x7E, and exactly one `dout_valid`, no further frames.
- `dout_ready`=0, send 0x11 then 0x22 → `dout`=0x11 held, `overrun`=1. Raise `dout_ready` → handshake, `overrun`=0. Send 0x33 → `dout`=0x33.
- Assert reset (0) mid data bit 4 of a frame, release, send 0x81 → no output for the aborted frame, then `dout`=0x81. Separately, change `conf` mid-frame → the current frame still decodes at the latched rate.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: conf field positions, receiver states and the baud divider.
// The transmitter uses the same package, so both ends agree on the conf layout.
package uart_pkg;

  localparam int CONF_BAUD_MSB = 7;
  localparam int CONF_BAUD_LSB = 5;
  localparam int CONF_PAR_EN   = 1;
  localparam int CONF_PAR_ODD  = 0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
  } rx_state_t;

  typedef struct packed {
    logic       frame_err;
    logic       parity_err;
    logic [7:0] data;
  } rx_frame_t;

  // Clocks per bit minus one; the bit counter runs 0..limit.
  function automatic logic [31:0] baud_limit(input int unsigned freq, input logic [2:0] sel);
    int unsigned baud;
    case (sel)
      3'd0:    baud = 1200;
      3'd1:    baud = 2400;
      3'd2:    baud = 4800;
      3'd3:    baud = 9600;
      3'd4:    baud = 19200;
      3'd5:    baud = 38400;
      3'd6:    baud = 57600;
      default: baud = 115200;
    endcase
    return freq / baud - 1;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the serial line; resets to the idle (high) level.
module uart_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (!reset) {q, meta} <= 2'b11;
    else        {q, meta} <= {meta, d};
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/8 data/optional parity/stop, mid-bit sampling,
// single-entry valid/ready output with a sticky overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int FREQ            = 50000000,
  parameter int CONFIG_WIDTH    = 8,
  parameter int UART_DATA_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rx,
  output logic [7:0]              dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    parity_err,
  output logic                    frame_err,
  output logic                    overrun,
  input  logic [CONFIG_WIDTH-1:0] conf
);

  localparam int BCW = $clog2(UART_DATA_WIDTH);

  rx_state_t                   st, st_nxt;
  logic                        rx_s;
  logic [CONFIG_WIDTH-1:0]     rx_conf;
  logic [31:0]                 baud_cnt, lim, half;
  logic [7:0][31:0]            lim_tab;
  logic [BCW-1:0]              bit_cnt;
  logic [UART_DATA_WIDTH-1:0]  shreg;
  logic                        par_bad, stop_bad, done_q;
  logic                        cnt_clr, cnt_tick, enter_data, smp, par_smp, done;
  logic                        hs, unused_conf;
  rx_frame_t                   frm, out_q;

  uart_sync2 u_sync (.clock(clock), .reset(reset), .d(rx), .q(rx_s));

  for (genvar g = 0; g < 8; g++) begin : g_lim
    assign lim_tab[g] = baud_limit(FREQ, 3'(g));
  end

  assign lim         = lim_tab[rx_conf[CONF_BAUD_MSB:CONF_BAUD_LSB]];
  assign half        = lim >> 1;
  assign cnt_tick    = (baud_cnt == lim);
  assign unused_conf = ^rx_conf;

  always_ff @(posedge clock) begin
    if (!reset) st <= ST_IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt     = st;
    cnt_clr    = 1'b0;
    enter_data = 1'b0;
    smp        = 1'b0;
    par_smp    = 1'b0;
    done       = 1'b0;
    case (st)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) st_nxt = ST_START;
      end
      // A start bit that is high again at mid-bit is a glitch.
      ST_START: if (baud_cnt == half) begin
        cnt_clr = 1'b1;
        if (rx_s) st_nxt = ST_IDLE;
        else begin
          st_nxt     = ST_DATA;
          enter_data = 1'b1;
        end
      end
      ST_DATA: if (cnt_tick) begin
        smp = 1'b1;
        if (bit_cnt == BCW'(UART_DATA_WIDTH - 1))
          st_nxt = rx_conf[CONF_PAR_EN] ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (cnt_tick) begin
        par_smp = 1'b1;
        st_nxt  = ST_STOP;
      end
      ST_STOP: if (cnt_tick) begin
        done   = 1'b1;
        st_nxt = rx_s ? ST_IDLE : ST_BREAK;
      end
      // Held-low line must return high before a new start bit is accepted.
      ST_BREAK: begin
        cnt_clr = 1'b1;
        if (rx_s) st_nxt = ST_IDLE;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_conf  <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bad  <= 1'b0;
      stop_bad <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (st == ST_IDLE) rx_conf <= conf;
      baud_cnt <= (cnt_clr || cnt_tick) ? '0 : baud_cnt + 32'd1;
      if (enter_data) begin
        bit_cnt <= '0;
        par_bad <= 1'b0;
      end
      if (smp) begin
        shreg[bit_cnt] <= rx_s;
        bit_cnt        <= bit_cnt + BCW'(1);
      end
      if (par_smp) par_bad <= rx_s ^ (^shreg) ^ rx_conf[CONF_PAR_ODD];
      if (done)    stop_bad <= ~rx_s;
      done_q <= done;
    end
  end

  assign frm = '{frame_err: stop_bad, parity_err: par_bad, data: shreg};
  assign hs  = dout_valid & dout_ready;

  // A frame landing in the same cycle as a handshake replaces the old one.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_q      <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (done_q && (!dout_valid || dout_ready)) begin
        out_q      <= frm;
        dout_valid <= 1'b1;
      end else if (hs) begin
        dout_valid <= 1'b0;
      end
      if (done_q && dout_valid && !dout_ready) overrun <= 1'b1;
      else if (hs)                             overrun <= 1'b0;
    end
  end

  assign dout       = out_q.data;
  assign parity_err = out_q.parity_err;
  assign frame_err  = out_q.frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and random frames against a frame-level model of the receiver.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int FREQ = 1152000;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       dout_ready = 1'b1;
  logic [7:0] conf = 8'hE0;
  logic [7:0] dout;
  logic       dout_valid, parity_err, frame_err, overrun;

  int total = 0;
  int bad = 0;
  int vcnt = 0;
  int v0;
  logic [9:0] got[$];
  logic [9:0] exp_q[$];

  uart_rx #(.FREQ(FREQ), .CONFIG_WIDTH(8), .UART_DATA_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .rx(rx),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
    .conf(conf)
  );

  always #5 clock = ~clock;

  // Every handshake delivers one frame to the host side.
  always @(negedge clock) begin
    if (dout_valid === 1'b1) vcnt++;
    if (dout_valid === 1'b1 && dout_ready === 1'b1)
      got.push_back({frame_err, parity_err, dout});
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one frame of bl cycles per bit; optionally hold the line low after the stop bit.
  task automatic send(input logic [7:0] d, input bit pen, input bit odd, input bit pbit,
                      input bit stop, input int bl, input int hold, input bit want);
    rx = 1'b0;
    cyc(bl);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      cyc(bl);
    end
    if (pen) begin
      rx = pbit;
      cyc(bl);
    end
    rx = stop;
    cyc(bl);
    if (hold > 0) cyc(hold * bl);
    rx = 1'b1;
    cyc(2 * bl);
    if (want) exp_q.push_back({~stop, pen & (pbit != ((^d) ^ odd)), d});
  endtask

  task automatic check_q(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk({tag, "_frame"}, 32'(got[i]), 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    bit pen, odd, pbit, stop;

    cyc(3);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_valid", 32'(dout_valid), 32'h0);
    chk("rst_perr", 32'(parity_err), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    reset = 1'b1;
    cyc(5);

    v0 = vcnt;
    send(8'hA5, 0, 0, 0, 1, 10, 0, 1);
    check_q("basic");
    chk("basic_pulse", 32'(vcnt - v0), 32'd1);

    conf = 8'hE2;
    send(8'h03, 1, 0, 0, 1, 10, 0, 1);
    send(8'h03, 1, 0, 1, 1, 10, 0, 1);
    conf = 8'hE3;
    send(8'h03, 1, 1, 1, 1, 10, 0, 1);
    check_q("parity");

    conf = 8'hE0;
    v0 = vcnt;
    rx = 1'b0;
    cyc(3);
    rx = 1'b1;
    cyc(30);
    chk("glitch_novalid", 32'(vcnt - v0), 32'd0);
    send(8'h5A, 0, 0, 0, 1, 10, 0, 1);
    check_q("glitch");

    v0 = vcnt;
    send(8'h7E, 0, 0, 0, 0, 10, 20, 1);
    cyc(20);
    check_q("ferr");
    chk("ferr_pulses", 32'(vcnt - v0), 32'd1);

    dout_ready = 1'b0;
    send(8'h11, 0, 0, 0, 1, 10, 0, 1);
    send(8'h22, 0, 0, 0, 1, 10, 0, 0);
    chk("ovr_dout", 32'(dout), 32'h11);
    chk("ovr_valid", 32'(dout_valid), 32'h1);
    chk("ovr_flag", 32'(overrun), 32'h1);
    dout_ready = 1'b1;
    cyc(2);
    chk("ovr_clear", 32'(overrun), 32'h0);
    chk("ovr_drop", 32'(dout_valid), 32'h0);
    send(8'h33, 0, 0, 0, 1, 10, 0, 1);
    check_q("ovr");

    v0 = vcnt;
    fork
      send(8'hF5, 0, 0, 0, 1, 10, 0, 0);
      begin
        cyc(55);
        reset = 1'b0;
        cyc(2);
        chk("midrst_dout", 32'(dout), 32'h0);
        chk("midrst_valid", 32'(dout_valid), 32'h0);
        reset = 1'b1;
      end
    join
    chk("midrst_noframe", 32'(vcnt - v0), 32'd0);
    send(8'h81, 0, 0, 0, 1, 10, 0, 1);
    check_q("midrst");

    fork
      send(8'hC3, 0, 0, 0, 1, 10, 0, 1);
      begin
        cyc(35);
        conf = 8'hC0;
      end
    join
    send(8'h96, 0, 0, 0, 1, 20, 0, 1);
    conf = 8'hE0;
    cyc(5);
    check_q("confchg");

    for (int n = 0; n < 10; n++) begin
      d    = 8'($urandom);
      pen  = 1'($urandom);
      odd  = 1'($urandom);
      pbit = 1'($urandom);
      stop = ($urandom_range(3) != 0);
      conf = {3'b111, 3'b000, pen, odd};
      cyc(2);
      send(d, pen, odd, pbit, stop, 10, 0, 1);
    end
    check_q("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
